// File: rtl/oneapi_pixel_gasket_pkg.sv
// Shared definitions for the oneAPI Avalon-ST <-> AXI4-Stream pixel gaskets:
// width derivation helpers, frame-tracking state and tuser bit positions.
package oneapi_pixel_gasket_pkg;

    // Avalon pads every channel up to the next power of two.
    function automatic int unsigned av_channel_bits(input int unsigned bits);
        return 32'd1 << $clog2(bits);
    endfunction

    // AXI video packs all channels of a pixel tightly, then rounds up to whole bytes.
    function automatic int unsigned axi_pixel_bits(input int unsigned bits,
                                                   input int unsigned channels);
        return 8 * ((bits * channels + 7) / 8);
    endfunction

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } gasket_state_e;

    localparam int unsigned SofTuserBit = 0;

endpackage

// File: rtl/oneapi_axs_skid_buffer.sv
// Two-entry ready/valid buffer with a registered input ready and a registered
// output payload; sustains one beat per clock with ready held high.
module oneapi_axs_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = in_valid_i & ready_q;
    assign pop  = (count_q != 2'd0) & out_ready_i;

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            // Ready for next cycle reflects this cycle's push and pop together.
            ready_q <= (count_d != 2'd2);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/oneapi_avs_to_axs_pixel_gasket.sv
// Avalon-ST pixel sink to AXI4-Stream pixel source: strips channel padding,
// repacks into byte-aligned AXI pixels and maps sop/eop to tuser[0]/tlast.
module oneapi_avs_to_axs_pixel_gasket
    import oneapi_pixel_gasket_pkg::*;
#(
    parameter int unsigned PARALLEL_PIXELS  = 4,
    parameter int unsigned BITS_PER_CHANNEL = 12,
    parameter int unsigned CHANNELS         = 3,
    localparam int unsigned BITS_PER_CHANNEL_AV  = av_channel_bits(BITS_PER_CHANNEL),
    localparam int unsigned BITS_PER_PIXEL_AV    = BITS_PER_CHANNEL_AV * CHANNELS,
    localparam int unsigned BITS_AV              = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
    localparam int unsigned EMPTY_BITS           = $clog2(BITS_AV / 8),
    localparam int unsigned BITS_PER_CHANNEL_AXI = BITS_PER_CHANNEL,
    localparam int unsigned BITS_PER_PIXEL_AXI   = axi_pixel_bits(BITS_PER_CHANNEL_AXI, CHANNELS),
    localparam int unsigned BITS_AXI             = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
    localparam int unsigned TUSER_BITS           = ceil_div(BITS_AXI, 8)
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset,
    output logic                  asi_ready,
    input  logic                  asi_valid,
    input  logic [BITS_AV-1:0]    asi_data,
    input  logic                  asi_startofpacket,
    input  logic                  asi_endofpacket,
    input  logic [EMPTY_BITS-1:0] asi_empty,
    input  logic                  axm_tready,
    output logic                  axm_tvalid,
    output logic [BITS_AXI-1:0]   axm_tdata,
    output logic                  axm_tlast,
    output logic [TUSER_BITS-1:0] axm_tuser,
    output logic [15:0]           stat_drop_count
);

    localparam int unsigned PayloadBits = TUSER_BITS + 1 + BITS_AXI;
    localparam int unsigned PixelBytes  = BITS_PER_PIXEL_AV / 8;
    localparam logic [BITS_PER_CHANNEL_AV-1:0] MASK_OUT =
        BITS_PER_CHANNEL_AV'((64'd1 << BITS_PER_CHANNEL_AXI) - 64'd1);

    gasket_state_e          state_q;
    logic [15:0]            drop_cnt_q;
    logic [BITS_AXI-1:0]    tdata_c;
    logic [TUSER_BITS-1:0]  tuser_c;
    int unsigned            invalid_px;
    logic                   accept;
    logic                   drop;
    logic                   skid_in_valid;
    logic [PayloadBits-1:0] skid_out;

    always_comb begin
        tdata_c    = '0;
        invalid_px = asi_endofpacket ? (32'(asi_empty) / PixelBytes) : 32'd0;
        for (int unsigned p = 0; p < PARALLEL_PIXELS; p++) begin
            // Pixels past the eop empty count stay zero; padding nibble stays zero.
            if (p + invalid_px < PARALLEL_PIXELS) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    tdata_c[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
                        BITS_PER_CHANNEL_AXI'(
                            asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV]
                            & MASK_OUT);
                end
            end
        end
        tuser_c              = '0;
        tuser_c[SofTuserBit] = asi_startofpacket;
    end

    assign accept        = asi_valid & asi_ready;
    assign drop          = (state_q == WAIT_SOF) & ~asi_startofpacket;
    assign skid_in_valid = asi_valid & ~drop;

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q    <= WAIT_SOF;
            drop_cnt_q <= 16'd0;
        end else if (accept) begin
            if (asi_startofpacket) begin
                state_q <= IN_FRAME;
            end else if (state_q == WAIT_SOF && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    oneapi_axs_skid_buffer #(
        .WIDTH (PayloadBits)
    ) u_skid (
        .clk_i       (csi_clk),
        .rst_i       (rsi_reset),
        .in_valid_i  (skid_in_valid),
        .in_ready_o  (asi_ready),
        .in_data_i   ({tuser_c, asi_endofpacket, tdata_c}),
        .out_valid_o (axm_tvalid),
        .out_ready_i (axm_tready),
        .out_data_o  (skid_out)
    );

    assign axm_tdata       = skid_out[BITS_AXI-1:0];
    assign axm_tlast       = skid_out[BITS_AXI];
    assign axm_tuser       = skid_out[PayloadBits-1 -: TUSER_BITS];
    assign stat_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_oneapi_avs_to_axs_pixel_gasket.sv
// Directed bench for the Avalon-ST to AXI4-Stream pixel gasket (default parameters).
module tb_oneapi_avs_to_axs_pixel_gasket;

    logic         csi_clk = 1'b0;
    logic         rsi_reset;
    logic         asi_ready;
    logic         asi_valid;
    logic [191:0] asi_data;
    logic         asi_startofpacket;
    logic         asi_endofpacket;
    logic [4:0]   asi_empty;
    logic         axm_tready;
    logic         axm_tvalid;
    logic [159:0] axm_tdata;
    logic         axm_tlast;
    logic [19:0]  axm_tuser;
    logic [15:0]  stat_drop_count;

    int errors = 0;
    int checks = 0;

    always #5 csi_clk = ~csi_clk;

    oneapi_avs_to_axs_pixel_gasket dut (
        .csi_clk           (csi_clk),
        .rsi_reset         (rsi_reset),
        .asi_ready         (asi_ready),
        .asi_valid         (asi_valid),
        .asi_data          (asi_data),
        .asi_startofpacket (asi_startofpacket),
        .asi_endofpacket   (asi_endofpacket),
        .asi_empty         (asi_empty),
        .axm_tready        (axm_tready),
        .axm_tvalid        (axm_tvalid),
        .axm_tdata         (axm_tdata),
        .axm_tlast         (axm_tlast),
        .axm_tuser         (axm_tuser),
        .stat_drop_count   (stat_drop_count)
    );

    typedef struct {
        logic       sop;
        logic       eop;
        logic [4:0] empty;
        logic [11:0] seed;
        logic [3:0] pad;
        int         nvalid;
        logic       exp_last;
        logic       exp_sof;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Channel (p,c) carries seed + 16*(p+1) + (c+1), with pad in the top nibble.
    function automatic logic [11:0] chval(input logic [11:0] seed, input int p, input int c);
        return seed + 12'(16 * (p + 1) + (c + 1));
    endfunction

    function automatic logic [191:0] mk_av(input logic [11:0] seed, input logic [3:0] pad);
        logic [191:0] r = '0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 3; c++)
                r[p*48 + c*16 +: 16] = {pad, chval(seed, p, c)};
        return r;
    endfunction

    function automatic logic [159:0] mk_axi(input logic [11:0] seed, input int nvalid);
        logic [159:0] r = '0;
        for (int p = 0; p < nvalid; p++)
            for (int c = 0; c < 3; c++)
                r[p*40 + c*12 +: 12] = chval(seed, p, c);
        return r;
    endfunction

    task automatic drive(input logic v, input logic sop, input logic eop, input logic [4:0] empty,
                         input logic [191:0] data);
        asi_valid         = v;
        asi_startofpacket = sop;
        asi_endofpacket   = eop;
        asi_empty         = empty;
        asi_data          = data;
    endtask

    task automatic run_stream(input int n, input bit rnd, output int acc_cycles);
        logic [180:0] expq [$];
        logic [180:0] e;
        logic [11:0]  seed;
        int in_i = 0;
        int out_i = 0;
        int cyc = 0;
        acc_cycles = 0;
        while ((in_i < n || out_i < n) && cyc < 4000) begin
            axm_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            seed = 12'(in_i * 37);
            drive(in_i < n, in_i == 0, (in_i % 10) == 9, 5'd0, mk_av(seed, 4'(in_i)));
            if (axm_tvalid && axm_tready) begin
                if (expq.size() == 0) begin
                    chk("stream_extra_beat", 256'(out_i), 256'(n));
                end else begin
                    e = expq.pop_front();
                    chk("stream_beat", 256'({axm_tuser, axm_tlast, axm_tdata}), 256'(e));
                end
                out_i++;
            end
            if (asi_valid && asi_ready) begin
                expq.push_back({19'd0, asi_startofpacket, asi_endofpacket, mk_axi(seed, 4)});
                in_i++;
                if (in_i == n) acc_cycles = cyc + 1;
            end
            @(negedge csi_clk);
            cyc++;
        end
        asi_valid = 1'b0;
        chk("stream_out_count", 256'(out_i), 256'(n));
        chk("stream_in_count", 256'(in_i), 256'(n));
    endtask

    initial begin
        int cycles;
        vecs[0] = '{1'b1, 1'b0, 5'd0,  12'h000, 4'h0, 4, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  12'h112, 4'hF, 4, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd12, 12'h200, 4'hA, 2, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  12'h300, 4'h5, 4, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 5'd31, 12'h400, 4'h3, 4, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd5,  12'h500, 4'hC, 4, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'd6,  12'h600, 4'h7, 3, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 5'd23, 12'h700, 4'h9, 1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 5'd24, 12'h800, 4'hE, 0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 5'd31, 12'h900, 4'h1, 0, 1'b1, 1'b1};

        rsi_reset  = 1'b1;
        axm_tready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0);
        repeat (3) @(negedge csi_clk);
        chk("rst_asi_ready", 256'(asi_ready), 256'(0));
        chk("rst_tvalid", 256'(axm_tvalid), 256'(0));
        chk("rst_tdata", 256'(axm_tdata), 256'(0));
        chk("rst_tlast", 256'(axm_tlast), 256'(0));
        chk("rst_tuser", 256'(axm_tuser), 256'(0));
        chk("rst_drop", 256'(stat_drop_count), 256'(0));
        rsi_reset = 1'b0;
        @(negedge csi_clk);
        chk("ready_after_release", 256'(asi_ready), 256'(1));

        // Pre-SOF beats are accepted and dropped.
        axm_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd0, mk_av(12'h0A0, 4'h2));
            @(negedge csi_clk);
            chk("drop_no_tvalid", 256'(axm_tvalid), 256'(0));
        end
        chk("drop_count", 256'(stat_drop_count), 256'(3));

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].sop, vecs[i].eop, vecs[i].empty, mk_av(vecs[i].seed, vecs[i].pad));
            @(negedge csi_clk);
            chk("vec_tvalid", 256'(axm_tvalid), 256'(1));
            chk("vec_tdata", 256'(axm_tdata), 256'(mk_axi(vecs[i].seed, vecs[i].nvalid)));
            chk("vec_tlast", 256'(axm_tlast), 256'(vecs[i].exp_last));
            chk("vec_tuser", 256'(axm_tuser), 256'({19'd0, vecs[i].exp_sof}));
            if (i == 0) begin
                chk("px0_literal", 256'(axm_tdata[35:0]), 256'(36'h013012011));
                chk("px0_pad", 256'(axm_tdata[39:36]), 256'(0));
            end
            if (i == 1) chk("mask_literal", 256'(axm_tdata[11:0]), 256'(12'h123));
        end
        chk("drop_count_frozen", 256'(stat_drop_count), 256'(3));
        asi_valid = 1'b0;
        @(negedge csi_clk);
        chk("drained_tvalid", 256'(axm_tvalid), 256'(0));

        run_stream(100, 1'b1, cycles);
        @(negedge csi_clk);
        run_stream(100, 1'b0, cycles);
        chk("throughput_cycles", 256'(cycles), 256'(100));

        // Fill both entries with tready low, then reset.
        axm_tready = 1'b0;
        for (int k = 0; k < 10 && asi_ready; k++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd0, mk_av(12'h0C0, 4'h4));
            @(negedge csi_clk);
        end
        asi_valid = 1'b0;
        chk("full_tvalid", 256'(axm_tvalid), 256'(1));
        chk("full_ready", 256'(asi_ready), 256'(0));
        rsi_reset = 1'b1;
        @(negedge csi_clk);
        chk("midrst_tvalid", 256'(axm_tvalid), 256'(0));
        chk("midrst_ready", 256'(asi_ready), 256'(0));
        chk("midrst_tdata", 256'(axm_tdata), 256'(0));
        rsi_reset = 1'b0;
        chk("release_ready_low", 256'(asi_ready), 256'(0));
        @(negedge csi_clk);
        chk("release_ready_high", 256'(asi_ready), 256'(1));
        axm_tready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd0, mk_av(12'h0D0, 4'h6));
        @(negedge csi_clk);
        asi_valid = 1'b0;
        chk("wait_sof_drop_tvalid", 256'(axm_tvalid), 256'(0));
        chk("wait_sof_drop_count", 256'(stat_drop_count), 256'(1));
        drive(1'b1, 1'b1, 1'b0, 5'd0, mk_av(12'h0E0, 4'h8));
        @(negedge csi_clk);
        asi_valid = 1'b0;
        chk("post_rst_sof_tvalid", 256'(axm_tvalid), 256'(1));
        chk("post_rst_sof_tuser", 256'(axm_tuser), 256'(1));
        chk("post_rst_sof_tdata", 256'(axm_tdata), 256'(mk_axi(12'h0E0, 4)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
